team_04_uart_rx: RTL and testbench

UART receiver that consumes the serial stream on the user-project input pin mprj_io[9] and delivers checked bytes to the core. It is the stage directly downstream of the pad: it synchronises the line, recovers 8E1-style frames (start, 8 data LSB-first, optional parity, stop), and presents each byte on a one-entry valid/ready output register with per-byte error flags.

---
 rtl/team_04_uart_pkg.sv | 16 +
 rtl/team_04_bit_timer.sv | 29 ++
 rtl/team_04_uart_rx.sv | 118 +++++++++++
 tb/tb_team_04_uart_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/team_04_uart_pkg.sv
// Shared types and constants for the team_04 UART receiver.
package team_04_uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 5208;  // 9600 baud at 50 MHz

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

endpackage

// File: rtl/team_04_bit_timer.sv
// Per-bit cycle counter: mid_tick marks the start-bit centre, bit_tick marks one full bit period.
module team_04_bit_timer
  import team_04_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic mid_tick,
  output logic bit_tick
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  // Self-wraps on bit_tick so consecutive data bits stay on the same phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (clr || bit_tick) cnt <= '0;
    else                      cnt <= cnt + CW'(1);
  end

  assign mid_tick = (cnt == CW'(HALF - 1));
  assign bit_tick = (cnt == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/team_04_uart_rx.sv
// UART receiver (start, 8 data LSB-first, optional parity, stop) with a one-entry valid/ready output.
// At chip level rx_in comes from io_in[9], with io_oeb[9] held at 1 so the pad stays an input.
module team_04_uart_rx
  import team_04_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int IW = $clog2(DATA_BITS);

  state_t               state, state_nxt;
  logic                 rx_meta, rx_s;
  logic                 mid_tick, bit_tick, tmr_clr;
  logic                 start_ok, shift_en, par_cap, deliver, ferr_ev;
  logic [DATA_BITS-1:0] shreg;
  logic [IW-1:0]        bit_idx;
  logic                 perr;

  // Line idles high, so the synchroniser resets to 1 to avoid a phantom start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  team_04_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (mid_tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (bit_tick && bit_idx == IW'(DATA_BITS - 1))
                   state_nxt = PARITY_EN ? PARITY : STOP;
      PARITY:    if (bit_tick) state_nxt = STOP;
      STOP:      if (bit_tick) state_nxt = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Timer is held clear while waiting for a falling edge and re-phased at the start-bit centre.
  always_comb begin
    tmr_clr  = (state == IDLE) || (state == WAIT_HIGH) || (state == START && mid_tick);
    start_ok = (state == START) && mid_tick && !rx_s;
    shift_en = (state == DATA) && bit_tick;
    par_cap  = (state == PARITY) && bit_tick;
    deliver  = (state == STOP) && bit_tick && rx_s;
    ferr_ev  = (state == STOP) && bit_tick && !rx_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_idx <= '0;
      perr    <= 1'b0;
    end else begin
      if (start_ok) begin
        bit_idx <= '0;
        perr    <= 1'b0;
      end
      if (shift_en) begin
        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + IW'(1);
      end
      if (par_cap) perr <= ^shreg ^ rx_s ^ PARITY_ODD;
    end
  end

  // A byte arriving while the register is still full is dropped; the held byte wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_valid      <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_err <= ferr_ev;
      overrun   <= deliver && rx_valid && !rx_ready;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data       <= shreg;
        rx_parity_err <= perr;
        rx_valid      <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_team_04_uart_rx.sv
// Directed bench for team_04_uart_rx: even-parity DUT with handshake, odd-parity DUT with ready tied high.
module tb_team_04_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 3 + HALF + 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_parity_err, rx_valid, frame_err, overrun;
  logic [7:0] o_data;
  logic       o_perr, o_valid, o_ferr, o_ovr;

  int         pass_cnt = 0;
  int         chk_cnt = 0;
  int         cyc = 0;
  int         last_t0 = 0;
  int         rise_cyc = 0;
  int         n_rise = 0;
  int         ferr_hi = 0;
  int         ovr_hi = 0;
  int         o_ferr_hi = 0;
  int         o_ovr_hi = 0;
  logic       prev_v = 1'b0;
  logic [7:0] o_last = 8'h00;
  logic       o_last_perr = 1'b0;
  logic [7:0] cap[$];

  team_04_uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
  );

  team_04_uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_data(o_data), .rx_parity_err(o_perr),
    .rx_valid(o_valid), .rx_ready(1'b1), .frame_err(o_ferr), .overrun(o_ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !prev_v) begin
      n_rise   = n_rise + 1;
      rise_cyc = cyc;
    end
    prev_v = rx_valid;
    if (frame_err) ferr_hi = ferr_hi + 1;
    if (overrun) ovr_hi = ovr_hi + 1;
    if (o_ferr) o_ferr_hi = o_ferr_hi + 1;
    if (o_ovr) o_ovr_hi = o_ovr_hi + 1;
    if (rx_valid && rx_ready) cap.push_back(rx_data);
    if (o_valid) begin
      o_last      = o_data;
      o_last_perr = o_perr;
    end
  end

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int stop_len);
    last_t0 = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    rx_in = stop;
    repeat (stop_len * CPB) @(negedge clk);
    rx_in = 1'b1;
  endtask

  task automatic ack();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk_cnt++; if (rx_data !== 8'h00) $display("FAIL rst_data got %h want 00", rx_data); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_parity_err !== 1'b0) $display("FAIL rst_perr got %b want 0", rx_parity_err); else pass_cnt++;
    chk_cnt++; if (frame_err !== 1'b0) $display("FAIL rst_ferr got %b want 0", frame_err); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL rst_ovr got %b want 0", overrun); else pass_cnt++;
    chk_cnt++; if (o_valid !== 1'b0) $display("FAIL rst_odd_valid got %b want 0", o_valid); else pass_cnt++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_even_ok();
    int n0, f0, lat;
    n0 = n_rise; f0 = ferr_hi;
    send_frame(8'hB1, 1'b0, 1'b1, 1);
    lat = rise_cyc - last_t0 - 1;
    chk_cnt++; if (n_rise !== n0 + 1) $display("FAIL even_rise got %0d want %0d", n_rise - n0, 1); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL even_valid got %b want 1", rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'hB1) $display("FAIL even_data got %h want b1", rx_data); else pass_cnt++;
    chk_cnt++; if (rx_parity_err !== 1'b0) $display("FAIL even_perr got %b want 0", rx_parity_err); else pass_cnt++;
    chk_cnt++; if (lat < LAT - 2 || lat > LAT + 2) $display("FAIL even_latency got %0d want %0d+-2", lat, LAT); else pass_cnt++;
    chk_cnt++; if (ferr_hi !== f0) $display("FAIL even_ferr got %0d want 0", ferr_hi - f0); else pass_cnt++;
    chk_cnt++; if (o_last !== 8'hB1 || o_last_perr !== 1'b1) $display("FAIL odd_perr0 got %h/%b want b1/1", o_last, o_last_perr); else pass_cnt++;
    ack();
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL even_ack got %b want 0", rx_valid); else pass_cnt++;
  endtask

  task automatic test_parity_err();
    send_frame(8'hB1, 1'b1, 1'b1, 1);
    chk_cnt++; if (rx_data !== 8'hB1) $display("FAIL perr_data got %h want b1", rx_data); else pass_cnt++;
    chk_cnt++; if (rx_parity_err !== 1'b1) $display("FAIL perr_flag got %b want 1", rx_parity_err); else pass_cnt++;
    chk_cnt++; if (o_last !== 8'hB1 || o_last_perr !== 1'b0) $display("FAIL odd_perr1 got %h/%b want b1/0", o_last, o_last_perr); else pass_cnt++;
    ack();
  endtask

  task automatic test_glitch();
    int n0;
    n0 = n_rise;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk_cnt++; if (n_rise !== n0) $display("FAIL glitch_novalid got %0d rises want 0", n_rise - n0); else pass_cnt++;
    send_frame(8'h5A, 1'b0, 1'b1, 1);
    chk_cnt++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) $display("FAIL glitch_next got %b/%h want 1/5a", rx_valid, rx_data); else pass_cnt++;
    chk_cnt++; if (rx_parity_err !== 1'b0) $display("FAIL glitch_perr got %b want 0", rx_parity_err); else pass_cnt++;
    ack();
  endtask

  task automatic test_frame_err();
    int n0, f0, of0;
    n0 = n_rise; f0 = ferr_hi; of0 = o_ferr_hi;
    send_frame(8'h3C, 1'b0, 1'b0, 3);
    repeat (CPB) @(negedge clk);
    chk_cnt++; if (ferr_hi !== f0 + 1) $display("FAIL ferr_pulse got %0d cycles want 1", ferr_hi - f0); else pass_cnt++;
    chk_cnt++; if (o_ferr_hi !== of0 + 1) $display("FAIL ferr_odd_pulse got %0d cycles want 1", o_ferr_hi - of0); else pass_cnt++;
    chk_cnt++; if (n_rise !== n0 || rx_valid !== 1'b0) $display("FAIL ferr_novalid got %0d/%b want 0/0", n_rise - n0, rx_valid); else pass_cnt++;
    send_frame(8'hC3, 1'b0, 1'b1, 1);
    chk_cnt++; if (rx_valid !== 1'b1 || rx_data !== 8'hC3) $display("FAIL ferr_next got %b/%h want 1/c3", rx_valid, rx_data); else pass_cnt++;
    ack();
  endtask

  task automatic test_overrun();
    int o0;
    o0 = ovr_hi;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1);
    send_frame(8'h22, 1'b0, 1'b1, 1);
    chk_cnt++; if (rx_data !== 8'h11) $display("FAIL ovr_hold got %h want 11", rx_data); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid got %b want 1", rx_valid); else pass_cnt++;
    chk_cnt++; if (ovr_hi !== o0 + 1) $display("FAIL ovr_pulse got %0d cycles want 1", ovr_hi - o0); else pass_cnt++;
    ack();
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL ovr_drop got %b want 0", rx_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cap.size();
    rx_ready = 1'b1;
    send_frame(8'h0F, 1'b0, 1'b1, 1);
    send_frame(8'h07, 1'b1, 1'b1, 1);
    send_frame(8'hF0, 1'b0, 1'b1, 1);
    repeat (CPB) @(negedge clk);
    rx_ready = 1'b0;
    chk_cnt++; if (cap.size() !== c0 + 3) $display("FAIL b2b_count got %0d want 3", cap.size() - c0); else pass_cnt++;
    if (cap.size() >= c0 + 3) begin
      chk_cnt++; if (cap[c0] !== 8'h0F) $display("FAIL b2b_b0 got %h want 0f", cap[c0]); else pass_cnt++;
      chk_cnt++; if (cap[c0+1] !== 8'h07) $display("FAIL b2b_b1 got %h want 07", cap[c0+1]); else pass_cnt++;
      chk_cnt++; if (cap[c0+2] !== 8'hF0) $display("FAIL b2b_b2 got %h want f0", cap[c0+2]); else pass_cnt++;
    end
    chk_cnt++; if (o_last !== 8'hF0 || o_last_perr !== 1'b1) $display("FAIL b2b_odd got %h/%b want f0/1", o_last, o_last_perr); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    send_frame(8'h3C, 1'b0, 1'b1, 1);
    chk_cnt++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C) $display("FAIL rmid_pre got %b/%h want 1/3c", rx_valid, rx_data); else pass_cnt++;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    #1;
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h00) $display("FAIL rmid_data got %h want 00", rx_data); else pass_cnt++;
    chk_cnt++; if (rx_parity_err !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0)
      $display("FAIL rmid_flags got %b%b%b want 000", rx_parity_err, frame_err, overrun); else pass_cnt++;
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(8'hA5, 1'b0, 1'b1, 1);
    chk_cnt++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5) $display("FAIL rmid_next got %b/%h want 1/a5", rx_valid, rx_data); else pass_cnt++;
    chk_cnt++; if (rx_parity_err !== 1'b0) $display("FAIL rmid_perr got %b want 0", rx_parity_err); else pass_cnt++;
    chk_cnt++; if (o_ovr_hi !== 0) $display("FAIL odd_ovr got %0d want 0", o_ovr_hi); else pass_cnt++;
    ack();
  endtask

  initial begin
    test_reset();
    test_even_ok();
    test_parity_err();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
